// File: rtl/palette_lut.sv
// Writable multi-bank colour palette with a two-stage registered pixel pipeline.
// Optional frame-stepped brightness fade is built when PALETTE_FADE_EN is defined.
module palette_lut #(
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CH_W        = 4,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned FADE_FRAMES = 2,
  localparam int unsigned BANK_W     = $clog2(NUM_BANKS),
  localparam int unsigned COL_W      = 3 * CH_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid_in,
  input  logic [IDX_W-1:0]  index,
  input  logic [BANK_W-1:0] bank_sel,
  output logic              pix_valid_out,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  input  logic              blank,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [COL_W-1:0]  wr_color,
  input  logic              frame_tick,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              fade_busy
);

  localparam int unsigned ADDR_W  = BANK_W + IDX_W;
  localparam int unsigned ENTRIES = 2 ** ADDR_W;

  logic [COL_W-1:0]  r_pal [ENTRIES];
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_en;
  logic              r_s1_valid;
  logic [COL_W-1:0]  r_s1_color;
  logic [COL_W-1:0]  w_s2_color;
  logic              r_out_valid;
  logic [COL_W-1:0]  r_out_color;

  assign w_rd_addr = {bank_sel, index};
  assign w_wr_addr = {wr_bank, wr_index};
  assign wr_ready  = blank;
  assign w_wr_en   = wr_valid & blank;

  // Palette storage; non-blocking update gives old-value read-during-write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_pal[i] <= {COL_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_pal[w_wr_addr] <= wr_color;
    end
  end

  // Stage 1: palette lookup.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_color <= {COL_W{1'b0}};
    end else begin
      r_s1_valid <= pix_valid_in;
      r_s1_color <= r_pal[w_rd_addr];
    end
  end

`ifdef PALETTE_FADE_EN
  localparam int unsigned CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CH_W:0] LVL_FULL = {1'b1, {CH_W{1'b0}}};
  localparam logic [CH_W:0] LVL_ZERO = {(CH_W+1){1'b0}};
  localparam logic [CH_W:0] LVL_ONE  = (CH_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} fade_state_t;

  fade_state_t      r_state, w_state_nxt;
  logic [CH_W:0]    r_level, w_level_nxt, w_level_step, w_start_target, w_run_target;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;

  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W:0]   lvl);
    logic [2*CH_W:0] prod;
    prod = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, lvl};
    return CH_W'(prod >> CH_W);
  endfunction

  // Fade state, level and frame-step counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_level <= LVL_FULL;
      r_cnt   <= CNT_ZERO;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Fade next-state: a start request overrides any tick in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_cnt_nxt      = r_cnt;
    w_dir_nxt      = r_dir;
    w_start_target = fade_dir ? LVL_FULL : LVL_ZERO;
    w_run_target   = r_dir ? LVL_FULL : LVL_ZERO;
    w_level_step   = r_dir ? (r_level + LVL_ONE) : (r_level - LVL_ONE);
    if (fade_start) begin
      w_dir_nxt   = fade_dir;
      w_cnt_nxt   = CNT_ZERO;
      w_state_nxt = (r_level == w_start_target) ? ST_IDLE : ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (frame_tick) begin
            if (r_cnt == CNT_LAST) begin
              w_cnt_nxt   = CNT_ZERO;
              w_level_nxt = w_level_step;
              w_state_nxt = (w_level_step == w_run_target) ? ST_IDLE : ST_RUN;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign fade_busy = (r_state == ST_RUN);

  // Stage-2 brightness scaling by the current level.
  always_comb begin
    w_s2_color = {scale_ch(r_s1_color[3*CH_W-1:2*CH_W], r_level),
                  scale_ch(r_s1_color[2*CH_W-1:CH_W],   r_level),
                  scale_ch(r_s1_color[CH_W-1:0],        r_level)};
  end
`else
  logic w_unused_fade;

  assign w_unused_fade = ^{fade_start, frame_tick, fade_dir, FADE_FRAMES[0]};
  assign fade_busy     = 1'b0;

  // Without fade, stage 2 passes the looked-up colour straight through.
  always_comb begin
    w_s2_color = r_s1_color;
  end
`endif

  // Stage 2: output register; colour holds while no valid pixel arrives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_out_color <= {COL_W{1'b0}};
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_color <= w_s2_color;
      end
    end
  end

  assign pix_valid_out = r_out_valid;
  assign red           = r_out_color[3*CH_W-1:2*CH_W];
  assign green         = r_out_color[2*CH_W-1:CH_W];
  assign blue          = r_out_color[CH_W-1:0];

endmodule
